// File: rtl/tdc_result_buffer.sv
// TDC result capture FIFO: latches {addr,data} at the end of each TDC read strobe and presents it FWFT.
// Optional macro TDC_BUF_TIMESTAMP_EN adds a per-word 16-bit cycle timestamp on ts_out.
module tdc_result_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [27:0]   data_in,
    input  logic [3:0]    addr_in,
    input  logic          CSN,
    input  logic          RDN,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    input  logic          overflow_clr
`ifdef TDC_BUF_TIMESTAMP_EN
    ,
    output logic [15:0]   ts_out
`endif
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reset: asynchronous assert, release re-timed through two flops.
    logic rst_meta_q;
    logic rst_n_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    // Stage 1: registered copies of the reader bus.
    logic        csn_q;
    logic        rdn_q;
    logic [27:0] data_q;
    logic [3:0]  addr_q;
    logic        armed_q;
    logic        capture;

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            csn_q   <= 1'b1;
            rdn_q   <= 1'b1;
            data_q  <= '0;
            addr_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            csn_q   <= CSN;
            rdn_q   <= RDN;
            data_q  <= data_in;
            addr_q  <= addr_in;
            // Only strobes that begin after RDN was seen idle-high following reset may capture.
            armed_q <= armed_q | RDN;
        end
    end

    assign capture = armed_q & ~csn_q & ~rdn_q & RDN;

    // FIFO control state.
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          empty;
    logic          full_int;
    logic          pop;
    logic          accept;
    logic          drop;

    assign empty    = (count_q == '0);
    assign full_int = (count_q == FULL_CNT);

    always_comb begin
        pop        = ~empty & rd_ready;
        accept     = capture & (~full_int | pop);
        drop       = capture & full_int & ~pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear wins: the clear is overtaken by the new event.
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = overflow_clr ? 8'd1 : sat_inc8(drop_cnt_q);
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage: data-only, no reset; the head is masked while empty.
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= {addr_q, data_q};
        end
    end

`ifdef TDC_BUF_TIMESTAMP_EN
    logic [15:0] ts_cnt_q;
    logic [15:0] ts_mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ts_mem_q[wr_ptr_q] <= ts_cnt_q;
        end
    end

    assign ts_out = empty ? '0 : ts_mem_q[rd_ptr_q];
`endif

    assign rd_valid = ~empty;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = full_int;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_tdc_result_buffer.sv
// Directed self-checking bench for tdc_result_buffer (default DEPTH=16).
`timescale 1ns/1ps

module tb_tdc_result_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [27:0] data_in;
  logic [3:0]  addr_in;
  logic        CSN;
  logic        RDN;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [4:0]  count;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        overflow_clr;
`ifdef TDC_BUF_TIMESTAMP_EN
  logic [15:0] ts_out;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tdc_result_buffer #(.DEPTH(16), .AW(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .addr_in      (addr_in),
    .CSN          (CSN),
    .RDN          (RDN),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .overflow_clr (overflow_clr)
`ifdef TDC_BUF_TIMESTAMP_EN
    ,
    .ts_out       (ts_out)
`endif
  );

  function automatic logic [31:0] w(input int i);
    return {i[3:0], i[27:0]};
  endfunction

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] word, input logic pop_at_end, input logic clr_at_end);
    CSN     = 1'b0;
    RDN     = 1'b0;
    addr_in = word[31:28];
    data_in = word[27:0];
    tick();
    CSN          = 1'b1;
    RDN          = 1'b1;
    addr_in      = 4'hF;
    data_in      = 28'hFFFFFFF;
    rd_ready     = pop_at_end;
    overflow_clr = clr_at_end;
    tick();
    rd_ready     = 1'b0;
    overflow_clr = 1'b0;
  endtask

  task automatic pop1();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n      = 1'b0;
    CSN          = 1'b1;
    RDN          = 1'b1;
    data_in      = '0;
    addr_in      = '0;
    rd_ready     = 1'b0;
    overflow_clr = 1'b0;
    tick();
    tick();

    chk("rst_valid", rd_valid === 1'b0, rd_valid, 1'b0);
    chk("rst_data", rd_data === 32'h0, rd_data, 32'h0);
    chk("rst_count", count === 5'd0, count, 5'd0);
    chk("rst_full", full === 1'b0, full, 1'b0);
    chk("rst_ovf", overflow === 1'b0, overflow, 1'b0);
    chk("rst_drop", drop_cnt === 8'd0, drop_cnt, 8'd0);
    chk("rst_csn_q", dut.csn_q === 1'b1, dut.csn_q, 1'b1);
    chk("rst_rdn_q", dut.rdn_q === 1'b1, dut.rdn_q, 1'b1);
    chk("rst_data_q", dut.data_q === 28'h0, dut.data_q, 28'h0);
    chk("rst_addr_q", dut.addr_q === 4'h0, dut.addr_q, 4'h0);

    reset_n = 1'b1;
    tick();
    tick();
    tick();

    CSN = 1'b0; RDN = 1'b0; addr_in = 4'h3; data_in = 28'h0ABCDEF;
    tick();
    chk("single_early", rd_valid === 1'b0, rd_valid, 1'b0);
    CSN = 1'b1; RDN = 1'b1; addr_in = 4'hF; data_in = 28'hFFFFFFF;
    tick();
    chk("single_valid", rd_valid === 1'b1, rd_valid, 1'b1);
    chk("single_data", rd_data === 32'h30ABCDEF, rd_data, 32'h30ABCDEF);
    chk("single_count", count === 5'd1, count, 5'd1);
    tick();
    chk("single_hold_valid", rd_valid === 1'b1, rd_valid, 1'b1);
    chk("single_hold_data", rd_data === 32'h30ABCDEF, rd_data, 32'h30ABCDEF);
    chk("single_hold_count", count === 5'd1, count, 5'd1);

    strobe(w(77), 1'b1, 1'b0);
    chk("pushpop1_count", count === 5'd1, count, 5'd1);
    chk("pushpop1_data", rd_data === w(77), rd_data, w(77));
    pop1();
    chk("drain1_count", count === 5'd0, count, 5'd0);
    chk("drain1_valid", rd_valid === 1'b0, rd_valid, 1'b0);

    pop1();
    pop1();
    chk("empty_pop_count", count === 5'd0, count, 5'd0);

    CSN = 1'b1; RDN = 1'b0; tick();
    RDN = 1'b1; tick(); tick();
    chk("csn_high_count", count === 5'd0, count, 5'd0);
    CSN = 1'b0; RDN = 1'b0; tick(); tick(); tick();
    chk("rdn_stuck_count", count === 5'd0, count, 5'd0);
    CSN = 1'b1; tick();
    RDN = 1'b1; tick(); tick();
    chk("rdn_stuck_after", count === 5'd0, count, 5'd0);

    for (int i = 0; i < 12; i++) strobe(w(i), 1'b0, 1'b0);
    chk("wrap_peak", count === 5'd12, count, 5'd12);
    for (int j = 0; j < 8; j++) begin
      chk("wrap_out_a", rd_data === w(j), rd_data, w(j));
      pop1();
    end
    chk("wrap_mid", count === 5'd4, count, 5'd4);
    for (int i = 12; i < 20; i++) strobe(w(i), 1'b0, 1'b0);
    chk("wrap_count2", count === 5'd12, count, 5'd12);
    for (int j = 8; j < 20; j++) begin
      chk("wrap_out_b", rd_data === w(j), rd_data, w(j));
      pop1();
    end
    chk("wrap_empty", count === 5'd0, count, 5'd0);

    for (int i = 0; i < 18; i++) strobe(w(i), 1'b0, 1'b0);
    chk("ovf_count", count === 5'd16, count, 5'd16);
    chk("ovf_full", full === 1'b1, full, 1'b1);
    chk("ovf_flag", overflow === 1'b1, overflow, 1'b1);
    chk("ovf_drop", drop_cnt === 8'd2, drop_cnt, 8'd2);
    chk("ovf_head", rd_data === w(0), rd_data, w(0));
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("clr_flag", overflow === 1'b0, overflow, 1'b0);
    chk("clr_drop", drop_cnt === 8'd0, drop_cnt, 8'd0);

    strobe(w(100), 1'b1, 1'b0);
    chk("fullpp_count", count === 5'd16, count, 5'd16);
    chk("fullpp_flag", overflow === 1'b0, overflow, 1'b0);
    chk("fullpp_drop", drop_cnt === 8'd0, drop_cnt, 8'd0);
    chk("fullpp_head", rd_data === w(1), rd_data, w(1));

    strobe(w(200), 1'b0, 1'b1);
    chk("clrdrop_flag", overflow === 1'b1, overflow, 1'b1);
    chk("clrdrop_drop", drop_cnt === 8'd1, drop_cnt, 8'd1);
    chk("clrdrop_count", count === 5'd16, count, 5'd16);

    for (int i = 0; i < 256; i++) strobe(w(300), 1'b0, 1'b0);
    chk("sat_drop", drop_cnt === 8'd255, drop_cnt, 8'd255);
    chk("sat_flag", overflow === 1'b1, overflow, 1'b1);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("sat_clr", drop_cnt === 8'd0, drop_cnt, 8'd0);

    for (int j = 1; j < 16; j++) begin
      chk("ovf_out", rd_data === w(j), rd_data, w(j));
      pop1();
    end
    chk("ovf_out_last", rd_data === w(100), rd_data, w(100));
    pop1();
    chk("ovf_drained", count === 5'd0, count, 5'd0);
    chk("ovf_drained_full", full === 1'b0, full, 1'b0);

    for (int i = 0; i < 5; i++) strobe(w(40 + i), 1'b0, 1'b0);
    chk("mid_count", count === 5'd5, count, 5'd5);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", rd_valid === 1'b0, rd_valid, 1'b0);
    chk("mid_rst_count", count === 5'd0, count, 5'd0);
    CSN = 1'b0; RDN = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    CSN = 1'b1; RDN = 1'b1;
    tick(); tick();
    chk("inflight_count", count === 5'd0, count, 5'd0);
    strobe(w(9), 1'b0, 1'b0);
    tick();
    chk("fresh_count", count === 5'd1, count, 5'd1);
    chk("fresh_data", rd_data === w(9), rd_data, w(9));
    pop1();
    chk("fresh_empty", count === 5'd0, count, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
